band_power_bank: RTL and testbench

Per-band power accumulator feeding the spectrum bar display. Consumes the FFT magnitude stream bin by bin and sums the magnitudes into NUM_BANDS display bands. On each `set_values_flag` pulse from `freqs_display` it commits the sums into display registers, applying peak-hold with linear decay, and clears the sums. It serves `freq_value` for the band index `freq_pos_needed` requested by `freqs_display`.

---
 rtl/band_power_bank.sv | 133 +++++++++++++
 tb/tb_band_power_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/band_power_bank.sv
// band_power_bank: sums FFT bin magnitudes into display bands and commits the
// sums to peak-hold display registers with linear decay on each commit request.
module band_power_bank #(
  parameter int unsigned NUM_BANDS     = 10,
  parameter int unsigned BINS_PER_BAND = 4,
  parameter int unsigned ACC_W         = 24,
  parameter int unsigned SHIFT         = 8,
  parameter int unsigned DECAY         = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bin_valid,
  input  logic [7:0]  bin_idx,
  input  logic [15:0] bin_mag,
  output logic        in_ready,
  input  logic        set_values_flag,
  input  logic [7:0]  freq_pos_needed,
  output logic [11:0] freq_value,
  output logic        busy,
  output logic        commit_done
);

  localparam int unsigned IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_BANDS - 1);

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_k;
  logic             r_pending;
  logic             r_done;
  logic [ACC_W-1:0] r_acc  [NUM_BANDS];
  logic [11:0]      r_disp [NUM_BANDS];
  logic [11:0]      r_freq;

  logic [7:0]       w_band;
  logic             w_band_ok;
  logic             w_xfer;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_new;
  logic [ACC_W-1:0] w_shifted;
  logic [11:0]      w_scaled;
  logic [11:0]      w_decayed;
  logic [11:0]      w_disp_new;
  logic             w_last;
  logic             w_restart;
  logic             w_pos_ok;

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state == S_COMMIT);
  assign commit_done = r_done;
  assign freq_value  = r_freq;

  assign w_band    = bin_idx / 8'(BINS_PER_BAND);
  assign w_band_ok = (w_band < 8'(NUM_BANDS));
  assign w_xfer    = bin_valid & in_ready;
  assign w_sum     = {1'b0, r_acc[w_band[IDX_W-1:0]]} + (ACC_W+1)'(bin_mag);
  assign w_acc_new = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

  assign w_shifted  = r_acc[r_k] >> SHIFT;
  assign w_scaled   = (w_shifted > ACC_W'(4095)) ? 12'd4095 : w_shifted[11:0];
  assign w_decayed  = (r_disp[r_k] < 12'(DECAY)) ? '0 : r_disp[r_k] - 12'(DECAY);
  assign w_disp_new = (w_scaled > w_decayed) ? w_scaled : w_decayed;

  assign w_last    = (r_k == LAST_K);
  // A flag arriving in the final band cycle is folded into the restart decision.
  assign w_restart = r_pending | set_values_flag;
  assign w_pos_ok  = (freq_pos_needed < 8'(NUM_BANDS));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> COMMIT on flag, COMMIT -> IDLE after last band unless restarting
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (set_values_flag) w_state_nxt = S_COMMIT;
      S_COMMIT: if (w_last && !w_restart) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Band counter, pending-request flag and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_COMMIT) && w_last;
      if (r_state == S_COMMIT) begin
        r_k <= w_last ? '0 : r_k + 1'b1;
        if (w_last)               r_pending <= 1'b0;
        else if (set_values_flag) r_pending <= 1'b1;
      end else begin
        r_k       <= '0;
        r_pending <= 1'b0;
      end
    end
  end

  // Accumulators: saturating add in IDLE, clear each band as it is committed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BANDS; i++) r_acc[i] <= '0;
    end else if (r_state == S_COMMIT) begin
      r_acc[r_k] <= '0;
    end else if (w_xfer && w_band_ok) begin
      r_acc[w_band[IDX_W-1:0]] <= w_acc_new;
    end
  end

  // Display registers: peak-hold with linear decay, one band per commit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BANDS; i++) r_disp[i] <= '0;
    end else if (r_state == S_COMMIT) begin
      r_disp[r_k] <= w_disp_new;
    end
  end

  // Registered read port, zero for out-of-range band indices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_freq <= '0;
    else if (w_pos_ok) r_freq <= r_disp[freq_pos_needed[IDX_W-1:0]];
    else               r_freq <= '0;
  end

endmodule

// File: tb/tb_band_power_bank.sv
// Directed testbench for band_power_bank with hand-computed expected values.
module tb_band_power_bank;

  logic        clk;
  logic        rst_n;
  logic        bin_valid;
  logic [7:0]  bin_idx;
  logic [15:0] bin_mag;
  logic        in_ready;
  logic        set_values_flag;
  logic [7:0]  freq_pos_needed;
  logic [11:0] freq_value;
  logic        busy;
  logic        commit_done;

  int total;
  int bad;

  band_power_bank #(
    .NUM_BANDS(10),
    .BINS_PER_BAND(4),
    .ACC_W(24),
    .SHIFT(8),
    .DECAY(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bin_valid(bin_valid),
    .bin_idx(bin_idx),
    .bin_mag(bin_mag),
    .in_ready(in_ready),
    .set_values_flag(set_values_flag),
    .freq_pos_needed(freq_pos_needed),
    .freq_value(freq_value),
    .busy(busy),
    .commit_done(commit_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] idx, input logic [15:0] mag);
    bin_valid = 1'b1;
    bin_idx   = idx;
    bin_mag   = mag;
    tick();
    bin_valid = 1'b0;
  endtask

  task automatic commit_wait(input string tag);
    logic ok;
    set_values_flag = 1'b1;
    tick();
    set_values_flag = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (commit_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic read_band(input string tag, input logic [7:0] b, input logic [11:0] exp);
    freq_pos_needed = b;
    tick();
    check(tag, 32'(freq_value), 32'(exp));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bin_valid = 1'b0;
    bin_idx = '0;
    bin_mag = '0;
    set_values_flag = 1'b0;
    freq_pos_needed = '0;
    #2;
    check("rst_freq_value", 32'(freq_value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_commit_done", 32'(commit_done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic commit: 4 x 0x4000 = 0x10000, >> 8 = 256
    for (int i = 0; i < 4; i++) send(8'(i), 16'h4000);
    commit_wait("basic_done");
    read_band("basic_b0", 8'd0, 12'd256);
    for (int b = 1; b < 10; b++) read_band("basic_bn", 8'(b), 12'd0);

    // Decay by 64 per empty commit, floored at 0
    commit_wait("decay_done"); read_band("decay_192", 8'd0, 12'd192);
    commit_wait("decay_done"); read_band("decay_128", 8'd0, 12'd128);
    commit_wait("decay_done"); read_band("decay_64", 8'd0, 12'd64);
    commit_wait("decay_done"); read_band("decay_0", 8'd0, 12'd0);
    commit_wait("decay_done"); read_band("decay_floor", 8'd0, 12'd0);
    send(8'd0, 16'h2000);
    commit_wait("decay_done");
    read_band("decay_new32", 8'd0, 12'd32);

    // Saturation: 1024 x 0xFFFF would exceed 24 bits; clamps, then 4095 after shift
    bin_valid = 1'b1;
    bin_idx = 8'd5;
    bin_mag = 16'hFFFF;
    repeat (1024) tick();
    bin_valid = 1'b0;
    commit_wait("sat_done");
    read_band("sat_b1", 8'd1, 12'd4095);
    read_band("sat_b0_decayed", 8'd0, 12'd0);
    commit_wait("sat_done2");
    read_band("sat_acc_cleared", 8'd1, 12'd4031);

    // Range checks from a clean state
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send(8'd40, 16'hFFFF);
    send(8'd255, 16'hFFFF);
    commit_wait("range_done");
    for (int b = 0; b < 10; b++) read_band("range_bn", 8'(b), 12'd0);
    for (int i = 0; i < 4; i++) send(8'(i), 16'h4000);
    commit_wait("range_done2");
    read_band("range_b0", 8'd0, 12'd256);
    read_band("range_pos10", 8'd10, 12'd0);
    read_band("range_pos200", 8'd200, 12'd0);

    // Handshake: flag in cycle t with bin_valid held high
    bin_valid = 1'b1;
    bin_idx = 8'd40;
    bin_mag = 16'd1;
    set_values_flag = 1'b1;
    check("hs_ready_t", 32'(in_ready), 32'd1);
    tick();
    set_values_flag = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check("hs_ready_low", 32'(in_ready), 32'd0);
      check("hs_busy", 32'(busy), 32'd1);
      tick();
    end
    check("hs_ready_t11", 32'(in_ready), 32'd1);
    check("hs_done_t11", 32'(commit_done), 32'd1);
    tick();
    bin_valid = 1'b0;
    check("hs_done_width", 32'(commit_done), 32'd0);

    // Pending: second flag at t+4 restarts the commit once
    set_values_flag = 1'b1;
    tick();
    set_values_flag = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 4) set_values_flag = 1'b1;
      check("pend_ready", 32'(in_ready), (c <= 20) ? 32'd0 : 32'd1);
      check("pend_done", 32'(commit_done), (c == 11 || c == 21) ? 32'd1 : 32'd0);
      tick();
      set_values_flag = 1'b0;
    end

    // Reset mid-commit
    for (int i = 0; i < 4; i++) send(8'(i), 16'h4000);
    commit_wait("rst_setup_done");
    read_band("rst_setup_b0", 8'd0, 12'd256);
    set_values_flag = 1'b1;
    tick();
    set_values_flag = 1'b0;
    repeat (4) tick();
    check("mid_commit_read", 32'(freq_value), 32'd192);
    rst_n = 1'b0;
    #1;
    check("mid_rst_freq", 32'(freq_value), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_done", 32'(commit_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    commit_wait("post_rst_done");
    for (int b = 0; b < 10; b++) read_band("post_rst_bn", 8'(b), 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
